peripheral_input_conditioner: RTL and testbench

Produces the peripheral status bus (`peripheral_status_bus_t`) from raw board switch and push-button pins, forming the input half of the peripheral interface opposite the control-bus output drivers. Each of the 21 raw inputs is synchronized into the system clock domain and debounced by a sampled stability counter. The block also emits one-cycle press and change pulses for polling-free CPU use. It sits between the top-level pins and the peripheral bus fabric.

---
 rtl/peripherals.sv | 17 +
 rtl/peripheral_input_conditioner_if.sv | 26 ++
 rtl/peripheral_input_conditioner.sv | 83 ++++++++
 tb/tb_peripheral_input_conditioner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/peripherals.sv
// Shared peripheral bus payload types.
package peripherals;

  typedef struct packed {
    logic down;
    logic up;
    logic right;
    logic left;
    logic center;
  } button_state_t;

  typedef struct packed {
    logic [15:0]   switch_state;
    button_state_t button_state;
  } peripheral_status_bus_t;

endpackage

// File: rtl/peripheral_input_conditioner_if.sv
// Raw pin inputs and debounced status outputs of the input conditioner.
interface peripheral_input_conditioner_if;
  import peripherals::*;

  logic [15:0]            sw_raw;
  logic [4:0]             btn_raw;
  peripheral_status_bus_t status;
  logic [4:0]             button_pressed;
  logic                   status_changed;

  modport master (
    output sw_raw,
    output btn_raw,
    input  status,
    input  button_pressed,
    input  status_changed
  );

  modport slave (
    input  sw_raw,
    input  btn_raw,
    output status,
    output button_pressed,
    output status_changed
  );
endinterface

// File: rtl/peripheral_input_conditioner.sv
// Synchronizes and debounces 16 switches and 5 buttons into the status bus,
// with registered press and change pulses.
module peripheral_input_conditioner #(
  parameter int unsigned SAMPLE_DIV     = 100000,
  parameter int unsigned STABLE_SAMPLES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  peripheral_input_conditioner_if.slave bus
);

  localparam int unsigned NIN  = 21;
  localparam int unsigned NBTN = 5;
  localparam int unsigned PW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CW   = $clog2(STABLE_SAMPLES) + 1;

  logic [NIN-1:0]  w_raw;
  logic [NIN-1:0]  r_meta;
  logic [NIN-1:0]  r_sync;
  logic [NIN-1:0]  r_deb;
  logic [CW-1:0]   r_cnt [NIN];
  logic [PW-1:0]   r_pcnt;
  logic [NBTN-1:0] r_pressed;
  logic            r_changed;

  logic            w_tick;
  logic [NIN-1:0]  w_deb_nxt;
  logic [NIN-1:0]  w_commit;
  logic [CW-1:0]   w_cnt_nxt [NIN];

  // Buttons occupy the low bits so the vector lines up with the status struct.
  assign w_raw  = {bus.sw_raw, bus.btn_raw};
  assign w_tick = (r_pcnt == PW'(SAMPLE_DIV - 1));

  // Per-input run counter: a matching sample restarts the run.
  always_comb begin
    w_deb_nxt = r_deb;
    w_cnt_nxt = r_cnt;
    w_commit  = '0;
    if (w_tick) begin
      for (int i = 0; i < NIN; i++) begin
        if (r_sync[i] == r_deb[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CW'(STABLE_SAMPLES - 1)) begin
          w_deb_nxt[i] = r_sync[i];
          w_cnt_nxt[i] = '0;
          w_commit[i]  = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta    <= '0;
      r_sync    <= '0;
      r_deb     <= '0;
      r_pcnt    <= '0;
      r_pressed <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < NIN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_meta    <= w_raw;
      r_sync    <= r_meta;
      r_deb     <= w_deb_nxt;
      r_pcnt    <= w_tick ? '0 : r_pcnt + PW'(1);
      r_pressed <= w_commit[NBTN-1:0] & w_deb_nxt[NBTN-1:0];
      r_changed <= |w_commit;
      for (int i = 0; i < NIN; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign bus.status         = peripherals::peripheral_status_bus_t'(r_deb);
  assign bus.button_pressed = r_pressed;
  assign bus.status_changed = r_changed;

endmodule

// File: tb/tb_peripheral_input_conditioner.sv
// Two conditioner instances (fast and prescaled) checked every cycle against a
// sliding-window reference: a level commits when the last N tick samples all oppose it.
module tb_peripheral_input_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] r_sw  = '0;
  logic [4:0]  r_btn = '0;

  peripheral_input_conditioner_if if_a ();
  peripheral_input_conditioner_if if_b ();

  assign if_a.sw_raw  = r_sw;
  assign if_a.btn_raw = r_btn;
  assign if_b.sw_raw  = r_sw;
  assign if_b.btn_raw = r_btn;

  peripheral_input_conditioner #(.SAMPLE_DIV(1), .STABLE_SAMPLES(4)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  peripheral_input_conditioner #(.SAMPLE_DIV(5), .STABLE_SAMPLES(3)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          m_div [2] = '{1, 5};
  int          m_n   [2] = '{4, 3};
  int          m_cyc [2];
  int          m_wcnt[2];
  logic [20:0] m_win [2][8];
  logic [20:0] m_d   [2];
  logic [4:0]  m_press[2];
  logic        m_chg [2];
  logic [20:0] m_pipe0, m_pipe1;

  task automatic model_clear();
    m_pipe0 = '0;
    m_pipe1 = '0;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 0; m_wcnt[i] = 0; m_d[i] = '0; m_press[i] = '0; m_chg[i] = 1'b0;
      for (int k = 0; k < 8; k++) m_win[i][k] = '0;
    end
  endtask

  initial model_clear();

  always @(posedge clk) begin
    if (rst_n) begin
      logic [20:0] s;
      logic        all_opp;
      s = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = {r_sw, r_btn};
      for (int i = 0; i < 2; i++) begin
        m_press[i] = '0;
        m_chg[i]   = 1'b0;
        if ((m_cyc[i] % m_div[i]) == m_div[i] - 1) begin
          for (int k = 7; k > 0; k--) m_win[i][k] = m_win[i][k-1];
          m_win[i][0] = s;
          if (m_wcnt[i] < 8) m_wcnt[i]++;
          for (int b = 0; b < 21; b++) begin
            all_opp = (m_wcnt[i] >= m_n[i]);
            for (int k = 0; k < m_n[i]; k++)
              if (m_win[i][k][b] == m_d[i][b]) all_opp = 1'b0;
            if (all_opp) begin
              m_d[i][b] = ~m_d[i][b];
              m_chg[i]  = 1'b1;
              if (b < 5 && m_d[i][b]) m_press[i][b] = 1'b1;
            end
          end
        end
        m_cyc[i]++;
      end
    end
  end

  task automatic check_all();
    chk("a_status",  21'(if_a.status),         m_d[0]);
    chk("a_pressed", 21'(if_a.button_pressed), 21'(m_press[0]));
    chk("a_changed", 21'(if_a.status_changed), 21'(m_chg[0]));
    chk("b_status",  21'(if_b.status),         m_d[1]);
    chk("b_pressed", 21'(if_b.button_pressed), 21'(m_press[1]));
    chk("b_changed", 21'(if_b.status_changed), 21'(m_chg[1]));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_status"},  21'(if_a.status),         21'(0));
    chk({tag, "_a_pressed"}, 21'(if_a.button_pressed), 21'(0));
    chk({tag, "_a_changed"}, 21'(if_a.status_changed), 21'(0));
    chk({tag, "_b_status"},  21'(if_b.status),         21'(0));
    chk({tag, "_b_pressed"}, 21'(if_b.button_pressed), 21'(0));
    chk({tag, "_b_changed"}, 21'(if_b.status_changed), 21'(0));
  endtask

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    #1 check_zero("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    step(20);

    r_btn[2] = 1'b1;              // basic press
    step(12);
    r_sw[7] = 1'b1; step(3); r_sw[7] = 1'b0; step(10);   // short glitch
    r_sw[7] = 1'b1; step(4); r_sw[7] = 1'b0; step(12);   // just long enough
    r_btn[2] = 1'b0;              // release
    step(25);

    r_sw = 16'hA5A5; r_btn = 5'b10001;   // simultaneous commits
    step(30);
    r_sw = '0; r_btn = '0;
    step(30);

    r_sw[0] = 1'b1;               // prescaled step
    step(30);
    for (int j = 0; j < 8; j++) begin    // bounce every 7 cycles
      r_sw[1] = ~r_sw[1];
      step(7);
    end
    r_sw[1] = 1'b0;
    step(30);

    for (int j = 0; j < 3000; j++) begin // random holds, glitches and bursts
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r == 0) begin
        r_btn = 5'($urandom);
        r_sw  = 16'($urandom);
      end else if (r < 4) begin
        int unsigned b;
        b = $urandom_range(0, 20);
        if (b < 5) r_btn[b] = ~r_btn[b];
        else       r_sw[b-5] = ~r_sw[b-5];
      end
      step(1);
    end

    // Mid-operation reset with committed bits and partial runs in flight
    r_sw = 16'hFFFF; r_btn = 5'h1F;
    step(40);
    r_sw = 16'h00F0;
    step(6);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    model_clear();
    @(negedge clk);
    check_zero("inrst");
    rst_n = 1'b1;
    step(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
